// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-memory access controller.
// EX/MEM store/load type codes, FSM states and a load-code decode helper.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MW_NONE = 2'b00,
    MW_SB   = 2'b01,
    MW_SH   = 2'b10,
    MW_SW   = 2'b11
  } mem_write_e;

  typedef enum logic [2:0] {
    MR_NONE = 3'b000,
    MR_LB   = 3'b001,
    MR_LBU  = 3'b010,
    MR_LH   = 3'b011,
    MR_LHU  = 3'b100,
    MR_LW   = 3'b101
  } mem_read_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } dmem_state_e;

  // Codes 110/111 are reserved and behave like "no load".
  function automatic logic mr_is_load(input logic [2:0] mr);
    return (mr >= 3'(MR_LB)) && (mr <= 3'(MR_LW));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, replicated store data,
// extended load data and misalignment detection for one access.
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]  mem_write_i,
  input  logic [2:0]  mem_read_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic        access_o,
  output logic        store_o,
  output logic        load_o,
  output logic [3:0]  be_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o,
  output logic        misalign_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // A store takes priority, so a simultaneous load code is ignored.
  assign store_o  = (mem_write_i != 2'(MW_NONE));
  assign load_o   = !store_o && mr_is_load(mem_read_i);
  assign access_o = store_o || load_o;

  assign byte_s = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign half_s = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

  // Decode lanes, extension and alignment for the current access type.
  always_comb begin
    be_o       = 4'b0000;
    st_data_o  = 32'h0000_0000;
    ld_data_o  = 32'h0000_0000;
    misalign_o = 1'b0;
    if (store_o) begin
      case (mem_write_i)
        MW_SB: begin
          be_o      = 4'b0001 << addr_lo_i;
          st_data_o = {4{wdata_i[7:0]}};
        end
        MW_SH: begin
          be_o       = 4'b0011 << {addr_lo_i[1], 1'b0};
          st_data_o  = {2{wdata_i[15:0]}};
          misalign_o = addr_lo_i[0];
        end
        MW_SW: begin
          be_o       = 4'b1111;
          st_data_o  = wdata_i;
          misalign_o = (addr_lo_i != 2'b00);
        end
        default: begin
          be_o = 4'b0000;
        end
      endcase
    end else if (load_o) begin
      be_o = 4'b1111;
      case (mem_read_i)
        MR_LB:  ld_data_o = {{24{byte_s[7]}}, byte_s};
        MR_LBU: ld_data_o = {24'h00_0000, byte_s};
        MR_LH: begin
          ld_data_o  = {{16{half_s[15]}}, half_s};
          misalign_o = addr_lo_i[0];
        end
        MR_LHU: begin
          ld_data_o  = {16'h0000, half_s};
          misalign_o = addr_lo_i[0];
        end
        MR_LW: begin
          ld_data_o  = rdata_i;
          misalign_o = (addr_lo_i != 2'b00);
        end
        default: ld_data_o = 32'h0000_0000;
      endcase
    end else begin
      be_o = 4'b0000;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage controller: sequences one data-memory req/ack access per
// instruction, stalls the pipeline meanwhile and reports misalign/timeout.
module dmem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mem_write_i,
  input  logic [2:0]  mem_read_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        dm_req_o,
  output logic        dm_we_o,
  output logic [3:0]  dm_be_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_wdata_o,
  input  logic        dm_ack_i,
  input  logic [31:0] dm_rdata_i
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      ldata_q, ldata_d;
  logic             lvalid_q, lvalid_d;
  logic             misalign_q, misalign_d;
  logic             bus_err_q, bus_err_d;
  logic             stall_s;
  logic             timeout_s;

  logic        access_s, store_s, load_s, mis_s;
  logic [3:0]  be_s;
  logic [31:0] st_data_s, ld_data_s;

  // EX/MEM is frozen while stalled, so live inputs still describe the access in REQ.
  mem_lane_align u_lane_align (
    .mem_write_i (mem_write_i),
    .mem_read_i  (mem_read_i),
    .addr_lo_i   (addr_i[1:0]),
    .wdata_i     (wdata_i),
    .rdata_i     (dm_rdata_i),
    .access_o    (access_s),
    .store_o     (store_s),
    .load_o      (load_s),
    .be_o        (be_s),
    .st_data_o   (st_data_s),
    .ld_data_o   (ld_data_s),
    .misalign_o  (mis_s)
  );

  assign timeout_s = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  // Next-state, register updates and combinational stall.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ldata_d    = ldata_q;
    lvalid_d   = 1'b0;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;
    stall_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access_s && mis_s) begin
          misalign_d = 1'b1;
        end else if (access_s) begin
          stall_s = 1'b1;
          req_d   = 1'b1;
          we_d    = store_s;
          be_d    = be_s;
          addr_d  = {addr_i[31:2], 2'b00};
          wdata_d = st_data_s;
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        stall_s = 1'b1;
        // Ack is tested first so it wins over a same-cycle timeout.
        if (dm_ack_i) begin
          req_d    = 1'b0;
          cnt_d    = {CNT_W{1'b0}};
          lvalid_d = load_s;
          if (load_s) begin
            ldata_d = ld_data_s;
          end else begin
            ldata_d = ldata_q;
          end
          state_d = ST_DONE;
        end else if (timeout_s) begin
          req_d     = 1'b0;
          cnt_d     = {CNT_W{1'b0}};
          lvalid_d  = load_s;
          ldata_d   = 32'h0000_0000;
          bus_err_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= 4'b0000;
      addr_q     <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      ldata_q    <= 32'h0000_0000;
      lvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ldata_q    <= ldata_d;
      lvalid_q   <= lvalid_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign stall_o      = stall_s && rst_n;
  assign load_data_o  = ldata_q;
  assign load_valid_o = lvalid_q;
  assign misalign_o   = misalign_q;
  assign bus_err_o    = bus_err_q;
  assign dm_req_o     = req_q;
  assign dm_we_o      = we_q;
  assign dm_be_o      = be_q;
  assign dm_addr_o    = addr_q;
  assign dm_wdata_o   = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios plus random
// accesses compared against an arithmetic reference model.
module tb_dmem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mem_write_i;
  logic [2:0]  mem_read_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, load_valid_o, misalign_o, bus_err_o;
  logic [31:0] load_data_o;
  logic        dm_req_o, dm_we_o;
  logic [3:0]  dm_be_o;
  logic [31:0] dm_addr_o, dm_wdata_o;
  logic        dm_ack_i;
  logic [31:0] dm_rdata_i;

  int errors = 0;
  int checks = 0;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_write_i  (mem_write_i),
    .mem_read_i   (mem_read_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .stall_o      (stall_o),
    .load_data_o  (load_data_o),
    .load_valid_o (load_valid_o),
    .misalign_o   (misalign_o),
    .bus_err_o    (bus_err_o),
    .dm_req_o     (dm_req_o),
    .dm_we_o      (dm_we_o),
    .dm_be_o      (dm_be_o),
    .dm_addr_o    (dm_addr_o),
    .dm_wdata_o   (dm_wdata_o),
    .dm_ack_i     (dm_ack_i),
    .dm_rdata_i   (dm_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: sizes, offsets and extension from plain arithmetic.
  function automatic bit m_is_load(input logic [1:0] mw, input logic [2:0] mr);
    return (mw == 2'd0) && (mr >= 3'd1) && (mr <= 3'd5);
  endfunction

  function automatic int m_size(input logic [1:0] mw, input logic [2:0] mr);
    if (mw == 2'd1) return 1;
    if (mw == 2'd2) return 2;
    if (mw == 2'd3) return 4;
    if (mr == 3'd1 || mr == 3'd2) return 1;
    if (mr == 3'd3 || mr == 3'd4) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] mw, input logic [2:0] mr, input logic [31:0] a);
    int mask;
    if (mw == 2'd0) return 4'hF;
    mask = (1 << m_size(mw, mr)) - 1;
    return 4'(mask << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] mw, input logic [31:0] w);
    if (mw == 2'd1) return (w & 32'hFF) * 32'h0101_0101;
    if (mw == 2'd2) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] mr, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] sh;
    int v;
    sh = rd >> (8 * (a % 4));
    case (mr)
      3'd1: begin v = int'(sh & 32'hFF); if (v > 127) v = v - 256; return 32'(v); end
      3'd2: return sh & 32'hFF;
      3'd3: begin v = int'(sh & 32'hFFFF); if (v > 32767) v = v - 65536; return 32'(v); end
      3'd4: return sh & 32'hFFFF;
      default: return rd;
    endcase
  endfunction

  // Drive one instruction into MEM and follow it until the pipeline advances.
  task automatic run_access(input logic [1:0] mw, input logic [2:0] mr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd, input int ack_at,
                            input string nm);
    bit acc, ld, mis, done, tout;
    int stalls, cyc;
    acc   = (mw != 2'd0) || (mr >= 3'd1 && mr <= 3'd5);
    ld    = m_is_load(mw, mr);
    mis   = acc && ((a % m_size(mw, mr)) != 0);
    done  = 1'b0;
    tout  = 1'b0;
    stalls = 0;
    cyc   = 0;
    mem_write_i = mw; mem_read_i = mr; addr_i = a; wdata_i = wd;
    #1;
    chk({nm, "_stall_idle"}, 32'(stall_o), 32'(acc && !mis));
    if (stall_o) stalls++;
    @(negedge clk);
    if (!acc) begin
      chk({nm, "_noacc_req"}, 32'(dm_req_o), 32'd0);
      chk({nm, "_noacc_mis"}, 32'(misalign_o), 32'd0);
    end else if (mis) begin
      chk({nm, "_misalign"}, 32'(misalign_o), 32'd1);
      chk({nm, "_mis_req"}, 32'(dm_req_o), 32'd0);
      chk({nm, "_mis_stall"}, 32'(stall_o), 32'd0);
    end else begin
      chk({nm, "_addr"}, dm_addr_o, a & 32'hFFFF_FFFC);
      chk({nm, "_be"}, 32'(dm_be_o), 32'(m_be(mw, mr, a)));
      chk({nm, "_we"}, 32'(dm_we_o), 32'(mw != 2'd0));
      if (mw != 2'd0) chk({nm, "_wdata"}, dm_wdata_o, m_wdata(mw, wd));
      while (!done && cyc < TO + 2) begin
        chk({nm, "_req_held"}, 32'(dm_req_o), 32'd1);
        if (stall_o) stalls++;
        if (cyc == ack_at) begin
          dm_ack_i = 1'b1; dm_rdata_i = rd; done = 1'b1;
        end else if (cyc == TO - 1) begin
          done = 1'b1; tout = 1'b1;
        end
        @(negedge clk);
        dm_ack_i = 1'b0; dm_rdata_i = $urandom;
        cyc++;
      end
      chk({nm, "_finished"}, 32'(done), 32'd1);
      chk({nm, "_done_stall"}, 32'(stall_o), 32'd0);
      chk({nm, "_done_req"}, 32'(dm_req_o), 32'd0);
      chk({nm, "_stall_cycles"}, 32'(stalls), 32'(cyc + 1));
      chk({nm, "_lvalid"}, 32'(load_valid_o), 32'(ld));
      chk({nm, "_bus_err"}, 32'(bus_err_o), 32'(tout));
      if (tout) chk({nm, "_ldata_to"}, load_data_o, 32'd0);
      else if (ld) chk({nm, "_ldata"}, load_data_o, m_load(mr, a, rd));
    end
    mem_write_i = 2'd0; mem_read_i = 3'd0;
    @(negedge clk);
    chk({nm, "_after_mis"}, 32'(misalign_o), 32'd0);
    chk({nm, "_after_err"}, 32'(bus_err_o), 32'd0);
    chk({nm, "_after_lv"}, 32'(load_valid_o), 32'd0);
    chk({nm, "_after_stall"}, 32'(stall_o), 32'd0);
  endtask

  initial begin
    logic [1:0]  rmw;
    rst_n = 1'b0; mem_write_i = 2'd0; mem_read_i = 3'd0; addr_i = 32'd0;
    wdata_i = 32'd0; dm_ack_i = 1'b0; dm_rdata_i = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(dm_req_o), 32'd0);
    chk("rst_be", 32'(dm_be_o), 32'd0);
    chk("rst_ldata", load_data_o, 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_access(2'd0, 3'd5, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1, "lw_ack2");
    run_access(2'd1, 3'd0, 32'h0000_0023, 32'h0000_00A5, 32'd0, 0, "sb_imm");
    run_access(2'd0, 3'd3, 32'h0000_0006, 32'd0, 32'h8001_1234, 0, "lh");
    run_access(2'd0, 3'd4, 32'h0000_0006, 32'd0, 32'h8001_1234, 0, "lhu");
    run_access(2'd3, 3'd0, 32'h0000_0002, 32'h1234_5678, 32'd0, 0, "sw_mis");
    run_access(2'd0, 3'd5, 32'h0000_0100, 32'd0, 32'h1111_1111, -1, "lw_timeout");
    run_access(2'd0, 3'd5, 32'h0000_0104, 32'd0, 32'h2222_2222, TO - 1, "lw_ack_at_to");
    run_access(2'd2, 3'd5, 32'h0000_0042, 32'hCAFE_F00D, 32'd0, 2, "sh_with_rd");
    run_access(2'd0, 3'd7, 32'h0000_0044, 32'd0, 32'd0, 0, "rd_reserved");

    // Reset while an access is outstanding, then a stray late ack.
    mem_write_i = 2'd0; mem_read_i = 3'd5; addr_i = 32'h0000_0040;
    @(negedge clk);
    chk("mid_req", 32'(dm_req_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    chk("mid_rst_req", 32'(dm_req_o), 32'd0);
    chk("mid_rst_we", 32'(dm_we_o), 32'd0);
    chk("mid_rst_be", 32'(dm_be_o), 32'd0);
    chk("mid_rst_addr", dm_addr_o, 32'd0);
    chk("mid_rst_wdata", dm_wdata_o, 32'd0);
    chk("mid_rst_lv", 32'(load_valid_o), 32'd0);
    rst_n = 1'b1; mem_read_i = 3'd0;
    #1;
    chk("post_rst_stall", 32'(stall_o), 32'd0);
    dm_ack_i = 1'b1; dm_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk);
    dm_ack_i = 1'b0;
    chk("late_ack_lv", 32'(load_valid_o), 32'd0);
    chk("late_ack_ldata", load_data_o, 32'd0);
    chk("late_ack_req", 32'(dm_req_o), 32'd0);
    chk("late_ack_stall", 32'(stall_o), 32'd0);
    run_access(2'd0, 3'd1, 32'h0000_0047, 32'd0, 32'h80FF_0000, 0, "lb_after_rst");

    for (int i = 0; i < 60; i++) begin
      rmw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) rmw = 2'd0;
      run_access(rmw, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 5)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
